// File: rtl/div_sqrt_2_if.sv
// Data bus for the x/sqrt(2) constant multiplier: one signed sample in and
// one signed result out per clock, with no handshake.
interface div_sqrt_2_if;
   logic signed [7:0] in;
   logic signed [7:0] out;

   modport master (output in, input out);
   modport slave  (input in, output out);
endinterface

// File: rtl/div_sqrt_2.sv
// Pipelined signed 8-bit multiply by 1/sqrt(2) using N shift-add terms of
// 0.10110101b, one term per stage, floor-truncated result.
module div_sqrt_2 #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   div_sqrt_2_if.slave  bus
);

   generate
      if (N < 1 || N > 5) begin : g_bad_n
         $error("div_sqrt_2: parameter N must be in 1..5");
      end
   endgenerate

   // Term idx (0-based) is the operand scaled by 2^8 then shifted right by
   // 1, 3, 4, 6 or 8; the scaling keeps every term exact.
   function automatic logic signed [15:0] term_of(input logic signed [7:0] x,
                                                  input int idx);
      logic signed [15:0] ext;
      ext = {x, 8'h00};
      case (idx)
         0:       term_of = ext >>> 4'd1;
         1:       term_of = ext >>> 4'd3;
         2:       term_of = ext >>> 4'd4;
         3:       term_of = ext >>> 4'd6;
         4:       term_of = ext >>> 4'd8;
         default: term_of = 16'sd0;
      endcase
   endfunction

   logic signed [7:0]  x_d   [0:N-1];
   logic signed [7:0]  x_q   [0:N-1];
   logic signed [15:0] sum_d [0:N-1];
   logic signed [15:0] sum_q [0:N-1];
   logic               unused_s;

   // Stage k adds term k to the partial sum carried with its own operand copy.
   always_comb begin
      x_d[0]   = bus.in;
      sum_d[0] = term_of(bus.in, 0);
      for (int k = 1; k < N; k++) begin
         x_d[k]   = x_q[k-1];
         sum_d[k] = sum_q[k-1] + term_of(x_q[k-1], k);
      end
   end

   // Pipeline registers, cleared immediately by the asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            x_q[k]   <= 8'sd0;
            sum_q[k] <= 16'sd0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            x_q[k]   <= x_d[k];
            sum_q[k] <= sum_d[k];
         end
      end
   end

   // Dropping the 8 fractional bits of the final sum floors the product.
   assign bus.out = sum_q[N-1][15:8];

   // The last operand copy and the fraction bits are not consumed downstream.
   assign unused_s = ^{x_q[N-1], sum_q[N-1][7:0]};

endmodule

// File: tb/tb_div_sqrt_2.sv
// Scoreboard bench for div_sqrt_2: five instances (N=1..5) share one stimulus
// stream; the driver queues expected results, a negedge monitor checks them.
module tb_div_sqrt_2;

   logic              clk  = 1'b0;
   logic              rst  = 1'b0;
   logic signed [7:0] in_s = 8'sd0;

   always #5 clk = ~clk;

   div_sqrt_2_if if1 ();
   div_sqrt_2_if if2 ();
   div_sqrt_2_if if3 ();
   div_sqrt_2_if if4 ();
   div_sqrt_2_if if5 ();

   assign if1.in = in_s;
   assign if2.in = in_s;
   assign if3.in = in_s;
   assign if4.in = in_s;
   assign if5.in = in_s;

   div_sqrt_2 #(.N(1)) u_n1 (.clk(clk), .rst(rst), .bus(if1));
   div_sqrt_2 #(.N(2)) u_n2 (.clk(clk), .rst(rst), .bus(if2));
   div_sqrt_2 #(.N(3)) u_n3 (.clk(clk), .rst(rst), .bus(if3));
   div_sqrt_2 #(.N(4)) u_n4 (.clk(clk), .rst(rst), .bus(if4));
   div_sqrt_2 #(.N(5)) u_n5 (.clk(clk), .rst(rst), .bus(if5));

   logic signed [7:0] outs [1:5];
   assign outs[1] = if1.out;
   assign outs[2] = if2.out;
   assign outs[3] = if3.out;
   assign outs[4] = if4.out;
   assign outs[5] = if5.out;

   typedef struct {
      int    epoch;
      int    n;
      int    due;
      int    val;
      string tag;
   } exp_t;

   exp_t  sb_q   [$];
   exp_t  keep_q [$];
   int    cyc       = 0;
   int    epoch     = 0;
   int    errors    = 0;
   int    checks    = 0;
   bit    final_chk = 1'b0;
   bit    done      = 1'b0;

   // Coefficient in 1/256 units after N terms: 0.5, 0.625, 0.6875, 0.703125, 0.70703125.
   function automatic int coef(input int n);
      case (n)
         1:       return 128;
         2:       return 160;
         3:       return 176;
         4:       return 180;
         5:       return 181;
         default: return 0;
      endcase
   endfunction

   function automatic int ref_of(input int v, input int n);
      return (v * coef(n)) >>> 8;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int n, input int due, input int val, input string tag);
      exp_t e;
      e.epoch = epoch;
      e.n     = n;
      e.due   = due;
      e.val   = val;
      e.tag   = tag;
      sb_q.push_back(e);
   endtask

   // Apply one sample; hand values override the model for N=1,3,5.
   task automatic drive(input int v, input bit hand, input int e1, input int e3,
                        input int e5, input string tag);
      int val;
      @(posedge clk);
      #1;
      in_s = 8'(v);
      for (int n = 1; n <= 5; n++) begin
         val = ref_of(v, n);
         if (hand && n == 1) val = e1;
         if (hand && n == 3) val = e3;
         if (hand && n == 5) val = e5;
         push(n, cyc + n, val, tag);
      end
   endtask

   task automatic expect_zero_now(input string tag);
      for (int n = 1; n <= 5; n++) push(n, cyc, 0, tag);
   endtask

   task automatic expect_zero_fill(input string tag);
      for (int n = 1; n <= 5; n++)
         for (int d = 1; d <= n; d++) push(n, cyc + d, 0, tag);
   endtask

   // Monitor: compare every expectation that falls due this cycle.
   always @(negedge clk) begin
      keep_q = {};
      foreach (sb_q[i]) begin
         if (sb_q[i].epoch == epoch) begin
            if (sb_q[i].due == cyc) begin
               checks++;
               if (int'(outs[sb_q[i].n]) != sb_q[i].val) begin
                  errors++;
                  $display("FAIL %s N=%0d cyc=%0d got=%0d expected=%0d",
                           sb_q[i].tag, sb_q[i].n, cyc, outs[sb_q[i].n], sb_q[i].val);
               end
            end else if (sb_q[i].due < cyc) begin
               checks++;
               errors++;
               $display("FAIL %s_missed N=%0d due=%0d got=none expected=%0d",
                        sb_q[i].tag, sb_q[i].n, sb_q[i].due, sb_q[i].val);
            end else begin
               keep_q.push_back(sb_q[i]);
            end
         end
      end
      sb_q = keep_q;
      if (final_chk && !done) begin
         checks++;
         if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb_q.size());
         end
         done = 1'b1;
      end
   end

   initial begin
      // Held in reset with a toggling operand: every output must stay 0.
      repeat (8) begin
         @(posedge clk);
         #1;
         in_s = (in_s == 8'sd44) ? 8'sd0 : 8'sd44;
         expect_zero_now("rst_hold");
      end

      @(posedge clk);
      #1;
      in_s = 8'sd0;
      rst  = 1'b1;
      expect_zero_now("post_rst");
      expect_zero_fill("post_rst_fill");

      repeat (5) drive(44, 1'b1, 22, 30, 31, "hold44");

      drive(-44,  1'b1, -22, -31, -32, "neg44");
      drive(127,  1'b1,  63,  87,  89, "max");
      drive(-128, 1'b1, -64, -88, -91, "min");
      drive(1,    1'b1,   0,   0,   0, "one");
      drive(-1,   1'b1,  -1,  -1,  -1, "neg_one");
      drive(0,    1'b1,   0,   0,   0, "zero");
      drive(-3,   1'b1,  -2,  -3,  -3, "neg3");
      drive(100,  1'b1,  50,  68,  70, "p100");

      // Reset asserted between edges with the pipe full.
      @(posedge clk);
      #2;
      rst = 1'b0;
      epoch++;
      expect_zero_now("async_rst");
      repeat (2) begin
         @(posedge clk);
         #1;
         expect_zero_now("async_rst_hold");
      end
      in_s = 8'sd0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      expect_zero_now("rerelease");
      expect_zero_fill("rerelease_fill");
      drive(100, 1'b1, 50, 68, 70, "after_rst");

      for (int v = -128; v <= 127; v++) drive(v, 1'b0, 0, 0, 0, "sweep");

      repeat (7) @(posedge clk);
      final_chk = 1'b1;
      for (int i = 0; i < 10 && !done; i++) @(posedge clk);
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL monitor_timeout got=not_done expected=done");
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
